// File: rtl/stepper_pkg.sv
// Shared types, coil table and phase helpers for the stepper axis controller.
package stepper_pkg;

    typedef enum logic [1:0] {
        WAVE = 2'd0,
        FULL = 2'd1,
        HALF = 2'd2
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Half-step coil patterns; index 0 is the rightmost entry.
    localparam logic [7:0][3:0] HALF_TABLE = {
        4'b1001, 4'b1000, 4'b1100, 4'b0100,
        4'b0110, 4'b0010, 4'b0011, 4'b0001
    };

    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd0:    return WAVE;
            2'd1:    return FULL;
            default: return HALF;
        endcase
    endfunction

    // Wave lives on even indices, full on odd indices.
    function automatic logic [2:0] snap_phase(input mode_e mode, input logic [2:0] phase);
        case (mode)
            WAVE:    return {phase[2:1], 1'b0};
            FULL:    return {phase[2:1], 1'b1};
            default: return phase;
        endcase
    endfunction

    function automatic logic signed [2:0] phase_step(input mode_e mode, input logic dir);
        logic signed [2:0] mag;
        mag = (mode == HALF) ? 3'sd1 : 3'sd2;
        return dir ? mag : -mag;
    endfunction

endpackage

// File: rtl/stepper_axis_if.sv
// Command handshake and coil/status bundle between the control FSM and the stepper axis.
interface stepper_axis_if #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 20,
    parameter int POS_W = 24
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [1:0]       cmd_mode;
    logic [CNT_W-1:0] cmd_steps;
    logic [DIV_W-1:0] cmd_period;
    logic             stop_req;
    logic             hold_en;
    logic [3:0]       coils;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [POS_W-1:0] position;

    modport master (
        output cmd_valid, cmd_dir, cmd_mode, cmd_steps, cmd_period, stop_req, hold_en,
        input  cmd_ready, coils, busy, done, aborted, position
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_mode, cmd_steps, cmd_period, stop_req, hold_en,
        output cmd_ready, coils, busy, done, aborted, position
    );
endinterface

// File: rtl/stepper_step_timer.sv
// Reloadable down-counter; tick fires while enabled and the count has reached zero.
module stepper_step_timer #(
    parameter int DIV_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [DIV_W-1:0] reload,
    output logic             tick
);
    logic [DIV_W-1:0] count_q;

    assign tick = enable && (count_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= reload;
        end else if (enable) begin
            count_q <= tick ? reload : count_q - DIV_W'(1);
        end
    end
endmodule

// File: rtl/stepper_axis.sv
// Unipolar 4-coil stepper controller: timed wave/full/half-step moves with abort,
// hold/release at rest and an absolute half-step position counter.
module stepper_axis
    import stepper_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int DIV_W = 20,
    parameter int POS_W = 24
) (
    input  logic           clk,
    input  logic           reset,
    stepper_axis_if.slave  bus
);
    state_e           state_q, state_d;
    logic [2:0]       phase_q;
    logic [3:0]       coils_q;
    logic [POS_W-1:0] position_q;
    logic             done_q;
    logic             aborted_q;
    logic [CNT_W-1:0] remaining_q;
    logic             dir_q;
    mode_e            mode_q;
    logic [DIV_W-1:0] period_m1_q;

    logic             accept;
    logic             stop;
    logic             tick;
    logic             step_now;
    logic             last_step;
    logic             zero_steps;
    mode_e            cmd_mode;
    logic [2:0]       snapped_phase;
    logic [DIV_W-1:0] cmd_period_m1;
    logic [DIV_W-1:0] timer_reload;
    logic signed [2:0] step_inc;
    logic [2:0]       phase_next;
    logic [POS_W-1:0] pos_delta;
    logic [3:0]       idle_coils;
    logic             cmd_ready;
    logic             busy;

    assign accept        = bus.cmd_valid && (state_q == IDLE);
    assign stop          = (state_q == RUN) && bus.stop_req;
    assign step_now      = (state_q == RUN) && tick && !bus.stop_req;
    assign last_step     = step_now && (remaining_q == CNT_W'(1));
    assign zero_steps    = (bus.cmd_steps == '0);
    assign cmd_mode      = decode_mode(bus.cmd_mode);
    assign snapped_phase = snap_phase(cmd_mode, phase_q);
    assign cmd_period_m1 = (bus.cmd_period == '0) ? '0 : bus.cmd_period - DIV_W'(1);
    assign timer_reload  = accept ? cmd_period_m1 : period_m1_q;
    assign step_inc      = phase_step(mode_q, dir_q);
    assign phase_next    = phase_q + $unsigned(step_inc);
    assign pos_delta     = {{(POS_W-3){step_inc[2]}}, step_inc};
    assign idle_coils    = bus.hold_en ? HALF_TABLE[phase_q] : 4'b0000;

    stepper_step_timer #(.DIV_W(DIV_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .enable (state_q == RUN),
        .reload (timer_reload),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && !zero_steps) state_d = RUN;
            RUN:  if (stop || last_step)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE:    cmd_ready = 1'b1;
            RUN:     busy      = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    // A zero-step command leaves the phase alone so the coils do not move.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= '0;
            coils_q     <= '0;
            position_q  <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            mode_q      <= WAVE;
            period_m1_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (accept) begin
                    aborted_q <= 1'b0;
                    if (zero_steps) begin
                        done_q  <= 1'b1;
                        coils_q <= idle_coils;
                    end else begin
                        dir_q       <= bus.cmd_dir;
                        mode_q      <= cmd_mode;
                        remaining_q <= bus.cmd_steps;
                        period_m1_q <= cmd_period_m1;
                        phase_q     <= snapped_phase;
                        coils_q     <= HALF_TABLE[snapped_phase];
                    end
                end else begin
                    coils_q <= idle_coils;
                end
            end else if (stop) begin
                done_q    <= 1'b1;
                aborted_q <= 1'b1;
            end else if (step_now) begin
                phase_q     <= phase_next;
                coils_q     <= HALF_TABLE[phase_next];
                position_q  <= position_q + pos_delta;
                remaining_q <= remaining_q - CNT_W'(1);
                if (last_step) done_q <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.busy      = busy;
    assign bus.coils     = coils_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
    assign bus.position  = position_q;

endmodule

// File: tb/tb_stepper_axis.sv
// Self-checking bench for stepper_axis: a move-level reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized commands.
module tb_stepper_axis;
    localparam int CNT_W = 16;
    localparam int DIV_W = 20;
    localparam int POS_W = 24;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   j;

    always #5 clk = ~clk;

    stepper_axis_if #(.CNT_W(CNT_W), .DIV_W(DIV_W), .POS_W(POS_W)) bus ();

    stepper_axis #(.CNT_W(CNT_W), .DIV_W(DIV_W), .POS_W(POS_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [3:0] tbl(input int idx);
        case (idx)
            0: return 4'b0001;
            1: return 4'b0011;
            2: return 4'b0010;
            3: return 4'b0110;
            4: return 4'b0100;
            5: return 4'b1100;
            6: return 4'b1000;
            default: return 4'b1001;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: a move is "elapsed cycles since accept"; a step lands whenever
    // that count is a multiple of the period, until the step budget or a stop ends it.
    bit         m_moving;
    int         m_phase, m_pos, m_elapsed, m_taken, m_steps, m_period, m_mode;
    bit         m_dir, m_done, m_aborted;
    logic [3:0] m_coils;

    always @(posedge clk or posedge reset) begin
        int d;
        if (reset) begin
            m_moving = 0; m_phase = 0; m_pos = 0; m_elapsed = 0; m_taken = 0;
            m_steps = 0; m_period = 1; m_mode = 0; m_dir = 0;
            m_done = 0; m_aborted = 0; m_coils = 4'b0000;
        end else begin
            m_done = 0;
            if (!m_moving) begin
                if (bus.cmd_valid) begin
                    m_aborted = 0;
                    if (bus.cmd_steps == 0) begin
                        m_done  = 1;
                        m_coils = bus.hold_en ? tbl(m_phase) : 4'b0000;
                    end else begin
                        m_dir    = bus.cmd_dir;
                        m_mode   = (bus.cmd_mode == 2'd3) ? 2 : int'(bus.cmd_mode);
                        m_steps  = int'(bus.cmd_steps);
                        m_period = (bus.cmd_period == 0) ? 1 : int'(bus.cmd_period);
                        if (m_mode == 0) m_phase = m_phase - (m_phase % 2);
                        if (m_mode == 1) m_phase = m_phase - (m_phase % 2) + 1;
                        m_coils   = tbl(m_phase);
                        m_moving  = 1;
                        m_elapsed = 0;
                        m_taken   = 0;
                    end
                end else begin
                    m_coils = bus.hold_en ? tbl(m_phase) : 4'b0000;
                end
            end else begin
                m_elapsed++;
                if (bus.stop_req) begin
                    m_moving = 0; m_done = 1; m_aborted = 1;
                end else if (m_elapsed % m_period == 0) begin
                    d = (m_mode == 2) ? 1 : 2;
                    if (!m_dir) d = -d;
                    m_phase = (m_phase + d + 8) % 8;
                    m_pos   = m_pos + d;
                    m_taken++;
                    m_coils = tbl(m_phase);
                    if (m_taken == m_steps) begin
                        m_moving = 0; m_done = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [POS_W-1:0] mp;
        if (!reset) begin
            mp = m_pos[POS_W-1:0];
            check("cmd_ready", 32'(bus.cmd_ready), 32'(!m_moving));
            check("busy",      32'(bus.busy),      32'(m_moving));
            check("coils",     32'(bus.coils),     32'(m_coils));
            check("done",      32'(bus.done),      32'(m_done));
            check("aborted",   32'(bus.aborted),   32'(m_aborted));
            check("position",  32'(bus.position),  32'(mp));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_coils", 32'(bus.coils), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic issue(input bit dir, input logic [1:0] mode, input int steps, input int period);
        @(negedge clk);
        check("issue_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_dir    = dir;
        bus.cmd_mode   = mode;
        bus.cmd_steps  = CNT_W'(steps);
        bus.cmd_period = DIV_W'(period);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        j = 1;
    endtask

    task automatic to_cycle(input int target);
        while (j < target) begin
            @(negedge clk);
            j++;
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_dir    = 1'b0;
        bus.cmd_mode   = 2'd0;
        bus.cmd_steps  = '0;
        bus.cmd_period = '0;
        bus.stop_req   = 1'b0;
        bus.hold_en    = 1'b0;
        #1;
        check("por_ready", 32'(bus.cmd_ready), 32'd1);
        check("por_pos", 32'(bus.position), 32'd0);
        #20;
        @(negedge clk);
        reset = 1'b0;

        // Half, reel out, 4 steps every 3 clocks, then release and hold.
        issue(1'b1, 2'd2, 4, 3);
        check("half_c1", 32'(bus.coils), 32'b0001);
        to_cycle(4);  check("half_c4", 32'(bus.coils), 32'b0011);
        to_cycle(12); check("half_busy12", 32'(bus.busy), 32'd1);
        to_cycle(13);
        check("half_c13", 32'(bus.coils), 32'b0100);
        check("half_done", 32'(bus.done), 32'd1);
        check("half_pos", 32'(bus.position), 32'd4);
        to_cycle(14); check("release_coils", 32'(bus.coils), 32'b0000);
        bus.hold_en = 1'b1;
        to_cycle(15); check("hold_coils", 32'(bus.coils), 32'b0100);

        // Wave, reel in, 3 steps at period 1.
        do_reset();
        issue(1'b0, 2'd0, 3, 1);
        check("wave_c1", 32'(bus.coils), 32'b0001);
        to_cycle(2); check("wave_c2", 32'(bus.coils), 32'b1000);
        to_cycle(4);
        check("wave_c4", 32'(bus.coils), 32'b0010);
        check("wave_done", 32'(bus.done), 32'd1);
        check("wave_pos", 32'(bus.position), 32'h00FF_FFFA);

        // Move to phase 2, then full mode snaps to 3.
        do_reset();
        issue(1'b1, 2'd2, 2, 1);
        to_cycle(4);
        issue(1'b1, 2'd1, 2, 2);
        check("full_c1", 32'(bus.coils), 32'b0110);
        to_cycle(3); check("full_c3", 32'(bus.coils), 32'b1100);
        to_cycle(5);
        check("full_c5", 32'(bus.coils), 32'b1001);
        check("full_pos", 32'(bus.position), 32'd6);

        // Zero-step command.
        to_cycle(7);
        issue(1'b1, 2'd0, 0, 5);
        check("zero_done", 32'(bus.done), 32'd1);
        check("zero_busy", 32'(bus.busy), 32'd0);
        check("zero_coils", 32'(bus.coils), 32'b1001);
        check("zero_pos", 32'(bus.position), 32'd6);
        check("zero_abort", 32'(bus.aborted), 32'd0);

        // Abort off a tick, then abort on a tick.
        do_reset();
        issue(1'b1, 2'd2, 100, 5);
        to_cycle(12); bus.stop_req = 1'b1;
        to_cycle(13); bus.stop_req = 1'b0;
        check("stop_done", 32'(bus.done), 32'd1);
        check("stop_abort", 32'(bus.aborted), 32'd1);
        check("stop_pos", 32'(bus.position), 32'd2);
        check("stop_busy", 32'(bus.busy), 32'd0);
        do_reset();
        issue(1'b1, 2'd2, 100, 5);
        to_cycle(15); bus.stop_req = 1'b1;
        to_cycle(16); bus.stop_req = 1'b0;
        check("stoptick_pos", 32'(bus.position), 32'd2);
        check("stoptick_abort", 32'(bus.aborted), 32'd1);

        // Reset in the middle of a move.
        do_reset();
        issue(1'b1, 2'd2, 50, 2);
        to_cycle(8);
        #2 reset = 1'b1;
        #1;
        check("midrst_coils", 32'(bus.coils), 32'd0);
        check("midrst_pos", 32'(bus.position), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("midrst_ready", 32'(bus.cmd_ready), 32'd1);

        // Randomized commands, stops and hold changes.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.cmd_valid  = ($urandom_range(0, 3) == 0);
            bus.cmd_dir    = 1'($urandom_range(0, 1));
            bus.cmd_mode   = 2'($urandom_range(0, 3));
            bus.cmd_steps  = CNT_W'($urandom_range(0, 7));
            bus.cmd_period = DIV_W'($urandom_range(0, 4));
            bus.stop_req   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) bus.hold_en = ~bus.hold_en;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.stop_req  = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stepper_axis.md
Name: stepper_axis

Overview:
- Parametrised unipolar stepper controller; next generation of the team's 4-coil spool motor driver.
- Executes move commands of N steps at a programmable step period, in wave, full (two-phase) or half-step mode.
- Tracks absolute position and supports abort and hold/release at rest.
- Sits between the level-finder control FSM (command handshake) and the coil driver pins.

Parameters:
- CNT_W, 16, width of the step-count field in a command.
- DIV_W, 20, width of the step-period field (clock cycles per step).
- POS_W, 24, width of the signed position counter, in half-step units.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high when in IDLE; command accepted on cmd_valid && cmd_ready.
- cmd_dir  in  1  1 = reel out (phase index increments), 0 = reel in (phase index decrements).
- cmd_mode  in  2  0 = wave, 1 = full, 2 = half; 3 is treated as half.
- cmd_steps  in  CNT_W  number of steps to take.
- cmd_period  in  DIV_W  clocks per step; 0 is treated as 1.
- stop_req  in  1  abort the current move.
- hold_en  in  1  1 = keep the last coil pattern energised in IDLE; 0 = coils 0000 in IDLE.
- coils  out  4  registered coil drive.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at the end of each command.
- aborted  out  1  status of the last command (1 = ended by stop_req); valid from the done pulse until the next accept.
- position  out  POS_W  signed absolute position.

Behaviour:
- Reset (asynchronous) values: state IDLE, phase 0, coils 0000, position 0, busy 0, done 0, aborted 0, timer 0, remaining 0. Because reset forces IDLE, cmd_ready reads 1 during reset.
- Half-step table, index 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
  - Wave mode uses even indices only; full mode uses odd indices only.
  - Step increment: ±2 in wave/full, ±1 in half. Phase index is 3 bits and wraps mod 8.
- On accept (cycle A):
  - Latch dir, mode, steps, and max(period,1).
  - Snap phase: wave clears bit0, full sets bit0, half leaves it unchanged. The snap is not a step and does not change position.
  - Clear aborted.
- Zero-step command: if steps == 0, stay in IDLE and pulse done at cycle A+1. No coil change.
- Run: if steps > 0, enter RUN at A+1.
  - coils = table[phase] from A+1 onward (this energises the snapped phase).
  - Step k (k = 1..steps) updates phase, coils and position on the clock edge ending cycle A + k*period.
  - position changes by ±1 per half step and ±2 per wave/full step; it wraps in two's complement with no saturation.
- Last step: on the same edge, the FSM returns to IDLE and done pulses. busy is high exactly from A+1 through A + steps*period.
- stop_req:
  - Sampled only in RUN.
  - The next edge returns to IDLE with no further step, pulses done and sets aborted=1.
  - If stop_req coincides with a step tick, the stop wins and the step is not taken.
  - Ignored in IDLE.
- cmd_valid while busy is ignored, since cmd_ready is low.
- cmd_period is sampled only at accept; changing it mid-move has no effect.
- IDLE coils: table[phase] if hold_en, else 0000. hold_en acts combinationally on the coils register input and takes effect on the next edge.
- Reset mid-move: coils drop to 0000 immediately; position is lost (returns to 0).
- FSM states: IDLE, RUN. Timer counts down from period-1; a step tick fires when the timer is 0, then the timer reloads.

Decomposition:
- stepper_pkg holds:
  - mode_e (WAVE, FULL, HALF);
  - state_e (IDLE, RUN);
  - HALF_TABLE constant (8 x 4 bits);
  - the phase-increment function (mode, dir) returning a signed 3-bit step.
- One sub-module, stepper_step_timer: reloadable down-counter, DIV_W wide, with load, enable and a tick output.

Test Plan:
- Half mode, dir=1, steps=4, period=3, phase 0 → coils 0011, 0010, 0110, 0100 at A+3, A+6, A+9, A+12; done at A+12; position=+4; busy high for 12 cycles.
- Wave mode, dir=0, steps=3, period=1, phase 0 → coils 0001 at A+1, then 1000, 0100, 0010; position=-6; done at A+3.
- Full mode from phase 2, dir=1, steps=2, period=2 → snap to index 3 (0110 at A+1), then 1100, 1001; position=+4.
- steps=0 → done at A+1; coils, position and busy unchanged; aborted=0.
- Half mode, steps=100, period=5, stop_req asserted at A+12 (coinciding with no tick) → exactly 2 steps taken, done and aborted at A+13, position=+2. Repeat with stop_req on a tick cycle → no step taken on that cycle.
- After a move, hold_en=0 → coils 0000; hold_en=1 → last table pattern. Assert reset mid-RUN → coils 0000 and position 0 immediately; cmd_ready=1 after release.
